// File: rtl/mem_dma.sv
// mem_dma: block copy/fill engine mastering a single-port synchronous RAM
module mem_dma #(
  parameter int WIDTH = 8,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_SIZE-1:0] src,
  input  logic [ADDR_SIZE-1:0] dst,
  input  logic [ADDR_SIZE:0]   len,
  input  logic [WIDTH-1:0]     fill_val,
  output logic                 busy,
  output logic                 done,
  output logic                 m_cs,
  output logic                 m_wen,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [WIDTH-1:0]     m_din,
  input  logic [WIDTH-1:0]     m_dout
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t               state;
  logic [ADDR_SIZE-1:0] src_ptr, dst_ptr;
  logic [ADDR_SIZE:0]   count;
  logic                 mode_r;
  logic [WIDTH-1:0]     fill_r;
  // Sequencer: latch operands at start, then alternate RD/WR (copy) or stream WR (fill)
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      mode_r  <= 1'b0;
      fill_r  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_r  <= mode;
          fill_r  <= fill_val;
          src_ptr <= src;
          dst_ptr <= dst;
          count   <= len;
          state   <= (len == '0) ? DONE : (mode ? WR : RD);
        end
        RD: state <= WR;
        WR: begin
          src_ptr <= src_ptr + ADDR_SIZE'(1);
          dst_ptr <= dst_ptr + ADDR_SIZE'(1);
          count   <= count - (ADDR_SIZE+1)'(1);
          state   <= (count == (ADDR_SIZE+1)'(1)) ? DONE : (mode_r ? WR : RD);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Memory port decodes from registered state only; copy data comes straight from the RAM's registered output
  always_comb begin
    busy   = state != IDLE;
    done   = state == DONE;
    m_cs   = (state == RD) || (state == WR);
    m_wen  = state == WR;
    m_addr = (state == RD) ? src_ptr : (state == WR) ? dst_ptr : '0;
    m_din  = (state == WR) ? (mode_r ? fill_r : m_dout) : '0;
  end
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: scoreboard bench for mem_dma with an attached behavioural RAM
module tb_mem_dma;
  localparam int W = 8;
  localparam int AW = 10;
  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic [W-1:0]  fill_val;
  logic          busy, done, m_cs, m_wen;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_din, m_dout;
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [W-1:0]  pl_data;
  logic [W-1:0]  ram   [1024];
  logic [W-1:0]  model [1024];
  logic [AW+W-1:0] sb_q[$];
  int errors = 0;
  int checks = 0;

  mem_dma #(.WIDTH(W), .ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .m_cs(m_cs),
    .m_wen(m_wen), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle registered read; bench preload port has priority
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (m_cs && m_wen) ram[m_addr] <= m_din;
    if (m_cs && !m_wen) m_dout <= ram[m_addr];
  end

  // Every DUT write is matched against the next expected (addr,data)
  always @(negedge clk) begin
    if (m_cs && m_wen) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL write_sb: unexpected write addr=%h data=%h, want none", m_addr, m_din);
      end else begin
        logic [AW+W-1:0] e;
        e = sb_q.pop_front();
        if ({m_addr, m_din} !== e) begin
          errors++;
          $display("FAIL write_sb: got addr=%h data=%h, want addr=%h data=%h",
                   m_addr, m_din, e[AW+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_fill(logic [AW-1:0] d, int n, logic [W-1:0] v);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = d + AW'(i);
      model[a] = v;
      sb_q.push_back({a, v});
    end
  endfunction

  function automatic void push_copy(logic [AW-1:0] s, logic [AW-1:0] d, int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = d + AW'(i);
      model[a] = model[s + AW'(i)];
      sb_q.push_back({a, model[a]});
    end
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    model[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Start pulse seen at "edge 0"; returns at the sample point of cycle 1
  task automatic go(input logic md, input logic [AW-1:0] s, input logic [AW-1:0] d,
                    input logic [AW:0] l, input logic [W-1:0] f);
    @(negedge clk);
    mode = md; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record per-cycle output bits (bit c = cycle c) for n cycles, driving start from smask
  task automatic run(input int n, input logic [31:0] smask, output logic [31:0] cs_m,
                     output logic [31:0] wen_m, output logic [31:0] busy_m, output logic [31:0] done_m);
    cs_m = '0; wen_m = '0; busy_m = '0; done_m = '0;
    for (int c = 1; c <= n; c++) begin
      cs_m[c] = m_cs; wen_m[c] = m_wen; busy_m[c] = busy; done_m[c] = done;
      start = smask[c];
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; mode = 1'b0; len = 11'd5;
    repeat (3) @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (m_cs !== 1'b0)   begin errors++; $display("FAIL reset_cs: got %b want 0", m_cs); end
    if (m_wen !== 1'b0)  begin errors++; $display("FAIL reset_wen: got %b want 0", m_wen); end
    if (m_addr !== '0)   begin errors++; $display("FAIL reset_addr: got %h want 0", m_addr); end
    if (m_din !== '0)    begin errors++; $display("FAIL reset_din: got %h want 0", m_din); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_fill;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    preload(10'h014, 8'hEE);
    push_fill(10'h010, 4, 8'hA5);
    go(1'b1, 10'h3AA, 10'h010, 11'd4, 8'hA5);
    run(8, '0, cs_m, wen_m, busy_m, done_m);
    checks += 4;
    if (wen_m !== 32'h1E)  begin errors++; $display("FAIL fill_wen: got %h want %h", wen_m, 32'h1E); end
    if (cs_m !== 32'h1E)   begin errors++; $display("FAIL fill_cs: got %h want %h", cs_m, 32'h1E); end
    if (done_m !== 32'h20) begin errors++; $display("FAIL fill_done: got %h want %h", done_m, 32'h20); end
    if (busy_m !== 32'h3E) begin errors++; $display("FAIL fill_busy: got %h want %h", busy_m, 32'h3E); end
    for (int a = 'h10; a <= 'h14; a++) begin
      checks++;
      if (ram[a] !== model[a]) begin errors++; $display("FAIL fill_mem[%h]: got %h want %h", a, ram[a], model[a]); end
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL fill_pending: got %0d writes left want 0", sb_q.size()); end
  endtask

  task automatic test_copy;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    preload(10'h020, 8'h11);
    preload(10'h021, 8'h22);
    preload(10'h022, 8'h33);
    push_copy(10'h020, 10'h040, 3);
    go(1'b0, 10'h020, 10'h040, 11'd3, 8'hFF);
    run(10, '0, cs_m, wen_m, busy_m, done_m);
    checks += 4;
    if (wen_m !== 32'h54)  begin errors++; $display("FAIL copy_wen: got %h want %h", wen_m, 32'h54); end
    if (cs_m !== 32'h7E)   begin errors++; $display("FAIL copy_cs: got %h want %h", cs_m, 32'h7E); end
    if (done_m !== 32'h80) begin errors++; $display("FAIL copy_done: got %h want %h", done_m, 32'h80); end
    if (busy_m !== 32'hFE) begin errors++; $display("FAIL copy_busy: got %h want %h", busy_m, 32'hFE); end
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (ram['h40+i] !== model['h40+i]) begin errors++; $display("FAIL copy_dst[%0d]: got %h want %h", i, ram['h40+i], model['h40+i]); end
      if (ram['h20+i] !== model['h20+i]) begin errors++; $display("FAIL copy_src[%0d]: got %h want %h", i, ram['h20+i], model['h20+i]); end
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL copy_pending: got %0d writes left want 0", sb_q.size()); end
  endtask

  task automatic test_zero_len;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    go(1'b0, 10'h020, 10'h040, 11'd0, 8'h00);
    run(4, '0, cs_m, wen_m, busy_m, done_m);
    checks += 3;
    if (cs_m !== 32'h0)   begin errors++; $display("FAIL zero_cs: got %h want 0", cs_m); end
    if (done_m !== 32'h2) begin errors++; $display("FAIL zero_done: got %h want %h", done_m, 32'h2); end
    if (busy_m !== 32'h2) begin errors++; $display("FAIL zero_busy: got %h want %h", busy_m, 32'h2); end
  endtask

  task automatic test_wrap_overlap;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    push_fill(10'h3FE, 4, 8'h5A);
    go(1'b1, 10'h000, 10'h3FE, 11'd4, 8'h5A);
    run(7, '0, cs_m, wen_m, busy_m, done_m);
    checks++;
    if (done_m !== 32'h20) begin errors++; $display("FAIL wrap_done: got %h want %h", done_m, 32'h20); end
    preload(10'h050, 8'h77);
    preload(10'h051, 8'h01);
    preload(10'h052, 8'h02);
    preload(10'h053, 8'h03);
    push_copy(10'h050, 10'h051, 3);
    go(1'b0, 10'h050, 10'h051, 11'd3, 8'h00);
    run(9, '0, cs_m, wen_m, busy_m, done_m);
    checks++;
    if (done_m !== 32'h80) begin errors++; $display("FAIL overlap_done: got %h want %h", done_m, 32'h80); end
    for (int a = 'h50; a <= 'h53; a++) begin
      checks++;
      if (ram[a] !== 8'h77) begin errors++; $display("FAIL overlap_mem[%h]: got %h want 77", a, ram[a]); end
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d writes left want 0", sb_q.size()); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    preload(10'h060, 8'hC1);
    preload(10'h061, 8'hC2);
    push_copy(10'h060, 10'h070, 2);
    go(1'b0, 10'h060, 10'h070, 11'd2, 8'h00);
    mode = 1'b1; src = 10'h000; dst = 10'h100; len = 11'd5; fill_val = 8'hDD;
    run(10, 32'h24, cs_m, wen_m, busy_m, done_m);
    checks += 3;
    if (wen_m !== 32'h14)  begin errors++; $display("FAIL busy_wen: got %h want %h", wen_m, 32'h14); end
    if (done_m !== 32'h20) begin errors++; $display("FAIL busy_done: got %h want %h", done_m, 32'h20); end
    if (busy_m !== 32'h3E) begin errors++; $display("FAIL busy_busy: got %h want %h", busy_m, 32'h3E); end
    checks += 2;
    if (ram['h70] !== 8'hC1) begin errors++; $display("FAIL busy_mem70: got %h want c1", ram['h70]); end
    if (ram['h71] !== 8'hC2) begin errors++; $display("FAIL busy_mem71: got %h want c2", ram['h71]); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL busy_pending: got %0d writes left want 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    push_fill(10'h090, 1, 8'h42);
    push_fill(10'h090, 1, 8'h42);
    go(1'b1, 10'h000, 10'h090, 11'd1, 8'h42);
    run(8, 32'hE, cs_m, wen_m, busy_m, done_m);
    checks += 3;
    if (wen_m !== 32'h12)  begin errors++; $display("FAIL b2b_wen: got %h want %h", wen_m, 32'h12); end
    if (done_m !== 32'h24) begin errors++; $display("FAIL b2b_done: got %h want %h", done_m, 32'h24); end
    if (busy_m !== 32'h36) begin errors++; $display("FAIL b2b_busy: got %h want %h", busy_m, 32'h36); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d writes left want 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] cs_m, wen_m, busy_m, done_m;
    int bad_done;
    bad_done = 0;
    preload(10'h083, 8'h99);
    push_fill(10'h080, 3, 8'h3C);
    go(1'b1, 10'h000, 10'h080, 11'd8, 8'h3C);
    for (int c = 1; c <= 3; c++) begin
      if (done) bad_done++;
      if (c == 3) reset = 1'b1;
      @(negedge clk);
    end
    checks += 4;
    if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (m_wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen: got %b want 0", m_wen); end
    if (m_cs !== 1'b0)  begin errors++; $display("FAIL rstmid_cs: got %b want 0", m_cs); end
    if (bad_done != 0)  begin errors++; $display("FAIL rstmid_early_done: got %0d pulses want 0", bad_done); end
    reset = 1'b0;
    run(6, '0, cs_m, wen_m, busy_m, done_m);
    checks += 2;
    if (cs_m !== 32'h0)   begin errors++; $display("FAIL rstmid_after_cs: got %h want 0", cs_m); end
    if (done_m !== 32'h0) begin errors++; $display("FAIL rstmid_after_done: got %h want 0", done_m); end
    checks += 2;
    if (ram['h82] !== 8'h3C) begin errors++; $display("FAIL rstmid_mem82: got %h want 3c", ram['h82]); end
    if (ram['h83] !== 8'h99) begin errors++; $display("FAIL rstmid_mem83: got %h want 99", ram['h83]); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL rstmid_pending: got %0d writes left want 0", sb_q.size()); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; m_dout = '0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    test_reset;
    test_fill;
    test_copy;
    test_zero_len;
    test_wrap_overlap;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
